// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, 8 data bits MSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit between the data bits and the stop bit.
module uart_tx_frame (
  input  logic       clk,
  input  logic       rst,
  input  logic       btick,
  input  logic [7:0] din,
  input  logic       wr,
  output logic       txd,
  output logic       tx_rdy,
  output logic       busy,
  output logic       done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t      state_q;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic [7:0]  shift_q;
  logic [2:0]  cnt_q;
  logic        txd_q;
  logic        done_q;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif

  logic        accept_d;

  // A write only lands in an empty holding register; the frame launch needs a full one,
  // so both can never touch hold_full_q on the same edge.
  always_comb begin
    accept_d = wr & ~hold_full_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      txd_q       <= 1'b1;
      done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept_d) begin
        hold_q      <= din;
        hold_full_q <= 1'b1;
      end
      if (btick) begin
        case (state_q)
          IDLE: begin
            if (hold_full_q) begin
              state_q     <= START;
              shift_q     <= hold_q;
              hold_full_q <= 1'b0;
              txd_q       <= 1'b0;
`ifdef UART_TX_PARITY_EN
              parity_q    <= ^hold_q;
`endif
            end
          end
          START: begin
            state_q <= DATA;
            txd_q   <= shift_q[7];
            shift_q <= {shift_q[6:0], 1'b0};
            cnt_q   <= '0;
          end
          DATA: begin
            if (cnt_q == 3'd7) begin
              cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              txd_q   <= parity_q;
`else
              state_q <= STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              txd_q   <= shift_q[7];
              shift_q <= {shift_q[6:0], 1'b0};
              cnt_q   <= cnt_q + 3'd1;
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state_q <= STOP;
            txd_q   <= 1'b1;
          end
`endif
          STOP: begin
            done_q <= 1'b1;
            // A preloaded byte goes straight into the next start bit, no idle bit between.
            if (hold_full_q) begin
              state_q     <= START;
              shift_q     <= hold_q;
              hold_full_q <= 1'b0;
              txd_q       <= 1'b0;
`ifdef UART_TX_PARITY_EN
              parity_q    <= ^hold_q;
`endif
            end else begin
              state_q <= IDLE;
              txd_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            txd_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign txd    = txd_q;
  assign tx_rdy = ~hold_full_q;
  assign busy   = (state_q != IDLE);
  assign done   = done_q;

endmodule
